// File: rtl/fft_stage_sched.sv
// Butterfly issue scheduler for an in-place radix-2 DIF FFT: walks stages/butterflies,
// delays addresses through the twiddle-multiplier latency and checks its valid alignment.
module fft_stage_sched #(
   parameter int SIZE_DATA_FI = 6,
   parameter int MULT_LATENCY = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    hold,
   input  logic                    mult_valid,
   output logic                    rd_en,
   output logic [SIZE_DATA_FI-1:0] rd_addr_a,
   output logic [SIZE_DATA_FI-1:0] rd_addr_b,
   output logic                    mult_en,
   output logic [15:0]             fi_deg,
   output logic                    wr_en,
   output logic [SIZE_DATA_FI-1:0] wr_addr_a,
   output logic [SIZE_DATA_FI-1:0] wr_addr_b,
   output logic [3:0]              stage,
   output logic                    busy,
   output logic                    done,
   output logic                    sync_err
);
   localparam int SW  = SIZE_DATA_FI;
   localparam int LAT = MULT_LATENCY;
   localparam int CW  = $clog2(LAT + 1) + 1;
   localparam logic [SW-1:0] A_ONE = 1;
   localparam logic [SW-2:0] B_ONE = 1;
   localparam logic [CW-1:0] C_ONE = 1;
   localparam logic [CW-1:0] C_END = CW'(LAT);
   localparam logic [3:0]    S_END = 4'(SW - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state, state_nx;
   logic [SW-2:0]   b, b_nx;
   logic [3:0]      stage_nx;
   logic [CW-1:0]   dcnt, dcnt_nx;
   logic            clr_err;

   logic [SW-1:0]   bx, span, mask, j, aa, fi;
   logic [LAT:0]    vld_pipe;
   logic [LAT:0][SW-1:0] pa_pipe, pb_pipe;
   logic [SW-1:0]   fi_r;

   // Butterfly b of stage s: insert a zero bit at position log2(span) to get the upper address.
   always_comb begin
      bx   = {1'b0, b};
      span = A_ONE << (S_END - stage);
      mask = span - A_ONE;
      j    = bx & mask;
      aa   = ((bx & ~mask) << 1) | j;
      fi   = j << stage;
   end

   always_comb begin
      state_nx = state;
      b_nx     = b;
      stage_nx = stage;
      dcnt_nx  = dcnt;
      rd_en    = 1'b0;
      clr_err  = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nx = ISSUE;
            b_nx     = '0;
            stage_nx = '0;
            clr_err  = 1'b1;
         end
         ISSUE: if (!hold) begin
            rd_en = 1'b1;
            b_nx  = b + B_ONE;
            if (&b) begin
               state_nx = DRAIN;
               dcnt_nx  = '0;
            end
         end
         // Drain lets the last write of the stage land before the next stage reads.
         DRAIN: begin
            if (dcnt == C_END) begin
               if (stage == S_END) state_nx = DONE;
               else begin
                  state_nx = ISSUE;
                  stage_nx = stage + 4'd1;
                  b_nx     = '0;
               end
            end else dcnt_nx = dcnt + C_ONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         b        <= '0;
         stage    <= '0;
         dcnt     <= '0;
         sync_err <= 1'b0;
      end else begin
         state <= state_nx;
         b     <= b_nx;
         stage <= stage_nx;
         dcnt  <= dcnt_nx;
         if (clr_err)                 sync_err <= 1'b0;
         else if (mult_valid != wr_en) sync_err <= 1'b1;
      end
   end

   // Stage 0 of the delay line is the buffer-read cycle; stage LAT is write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         pa_pipe  <= '0;
         pb_pipe  <= '0;
         fi_r     <= '0;
      end else begin
         vld_pipe[0] <= rd_en;
         pa_pipe[0]  <= aa;
         pb_pipe[0]  <= aa | span;
         fi_r        <= rd_en ? fi : '0;
         for (int k = 1; k <= LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            pa_pipe[k]  <= pa_pipe[k-1];
            pb_pipe[k]  <= pb_pipe[k-1];
         end
      end
   end

   assign rd_addr_a = rd_en ? aa : '0;
   assign rd_addr_b = rd_en ? (aa | span) : '0;
   assign mult_en   = vld_pipe[0];
   assign fi_deg    = mult_en ? 16'(fi_r) : 16'd0;
   assign wr_en     = vld_pipe[LAT];
   assign wr_addr_a = wr_en ? pa_pipe[LAT] : '0;
   assign wr_addr_b = wr_en ? pb_pipe[LAT] : '0;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
endmodule

// File: tb/tb_fft_stage_sched.sv
// Randomized bench for fft_stage_sched: an N=8 instance against a schedule model,
// plus an N=64 instance checked by event counts and address formula.
module tb_fft_stage_sched;
   localparam int LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic st8, hd8, mv8, rd8, me8, wr8, bsy8, dn8, se8;
   logic [2:0] ra8, rb8, wa8, wb8;
   logic [15:0] fi8;
   logic [3:0] stg8;

   logic st64, hd64, mv64, rd64, me64, wr64, bsy64, dn64, se64;
   logic [5:0] ra64, rb64, wa64, wb64;
   logic [15:0] fi64;
   logic [3:0] stg64;
   logic [LAT-1:0] msr;

   fft_stage_sched #(.SIZE_DATA_FI(3), .MULT_LATENCY(LAT)) u8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .hold(hd8), .mult_valid(mv8),
      .rd_en(rd8), .rd_addr_a(ra8), .rd_addr_b(rb8), .mult_en(me8), .fi_deg(fi8),
      .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8), .stage(stg8),
      .busy(bsy8), .done(dn8), .sync_err(se8));

   fft_stage_sched #(.SIZE_DATA_FI(6), .MULT_LATENCY(LAT)) u64 (
      .clk(clk), .rst_n(rst_n), .start(st64), .hold(hd64), .mult_valid(mv64),
      .rd_en(rd64), .rd_addr_a(ra64), .rd_addr_b(rb64), .mult_en(me64), .fi_deg(fi64),
      .wr_en(wr64), .wr_addr_a(wa64), .wr_addr_b(wb64), .stage(stg64),
      .busy(bsy64), .done(dn64), .sync_err(se64));

   // Ideal twiddle multiplier for the large instance: outValid = en delayed LAT.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) msr <= '0;
      else        msr <= {msr[LAT-2:0], me64};
   assign mv64 = msr[LAT-1];

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference schedule for N=8, indexed by cycle relative to the start cycle.
   bit hmask [0:199];
   int e_rd [0:199], e_a [0:199], e_b [0:199], e_me [0:199], e_fi [0:199];
   int e_wr [0:199], e_wa [0:199], e_wb [0:199], e_stg [0:199];
   int e_done, err_prev, stg_prev;

   task automatic build();
      int t, t0, span, j, g, a;
      for (int k = 0; k < 200; k++) begin
         e_rd[k] = 0; e_a[k] = 0; e_b[k] = 0; e_me[k] = 0; e_fi[k] = 0;
         e_wr[k] = 0; e_wa[k] = 0; e_wb[k] = 0; e_stg[k] = 0;
      end
      t = 1;
      for (int s = 0; s < 3; s++) begin
         t0 = t;
         for (int bb = 0; bb < 4; bb++) begin
            while (hmask[t]) t++;
            span = 8 >> (s + 1);
            j = bb % span;
            g = bb / span;
            a = 2 * g * span + j;
            e_rd[t] = 1; e_a[t] = a; e_b[t] = a + span;
            e_me[t+1] = 1; e_fi[t+1] = j << s;
            e_wr[t+1+LAT] = 1; e_wa[t+1+LAT] = a; e_wb[t+1+LAT] = a + span;
            t++;
         end
         t += LAT + 1;
         for (int k = t0; k < t; k++) e_stg[k] = s;
      end
      e_done = t;
      e_stg[t] = 2;
   endtask

   // drop_n: index of the write event whose mult_valid is withheld (-1 none).
   task automatic run8(input int drop_n, input int rst_at, input int xstart);
      int drop, n;
      build();
      drop = -1; n = 0;
      for (int k = 0; k < 200; k++)
         if (e_wr[k] == 1) begin
            if (n == drop_n) drop = k;
            n++;
         end
      for (int k = 0; k <= e_done + 2; k++) begin
         @(negedge clk);
         st8 = (k == 0) || (k == xstart);
         hd8 = hmask[k];
         mv8 = (e_wr[k] == 1) && (k != drop);
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_rd", rd8, 0);   chk("rst_me", me8, 0);   chk("rst_wr", wr8, 0);
            chk("rst_fi", fi8, 0);   chk("rst_busy", bsy8, 0); chk("rst_done", dn8, 0);
            chk("rst_serr", se8, 0); chk("rst_stage", stg8, 0);
            chk("rst_ra", ra8, 0);   chk("rst_rb", rb8, 0);
            @(negedge clk);
            rst_n = 1'b1; st8 = 1'b0; hd8 = 1'b0; mv8 = 1'b0;
            for (int q = 0; q < 8; q++) begin
               @(negedge clk); #1;
               chk("post_rst_wr", wr8, 0);
               chk("post_rst_busy", bsy8, 0);
            end
            err_prev = 0; stg_prev = 0;
            return;
         end
         #1;
         chk("rd_en", rd8, e_rd[k]);
         if (e_rd[k] == 1) begin
            chk("rd_addr_a", ra8, e_a[k]);
            chk("rd_addr_b", rb8, e_b[k]);
         end
         chk("mult_en", me8, e_me[k]);
         chk("fi_deg", fi8, e_fi[k]);
         chk("wr_en", wr8, e_wr[k]);
         if (e_wr[k] == 1) begin
            chk("wr_addr_a", wa8, e_wa[k]);
            chk("wr_addr_b", wb8, e_wb[k]);
         end
         chk("done", dn8, int'(k == e_done));
         chk("busy", bsy8, int'(k >= 1 && k <= e_done));
         chk("stage", stg8, (k == 0) ? stg_prev : (k <= e_done) ? e_stg[k] : 2);
         chk("sync_err", se8, (k == 0) ? err_prev : int'(drop >= 0 && k > drop));
      end
      st8 = 1'b0; hd8 = 1'b0; mv8 = 1'b0;
      err_prev = int'(drop >= 0);
      stg_prev = 2;
   endtask

   task automatic clr_hold();
      for (int k = 0; k < 200; k++) hmask[k] = 1'b0;
   endtask

   initial begin
      int n_rd, n_wr, mx, dc, s, bb, span, j, a;
      rst_n = 1'b0;
      st8 = 1'b0; hd8 = 1'b0; mv8 = 1'b0;
      st64 = 1'b0; hd64 = 1'b0;
      err_prev = 0; stg_prev = 0;
      clr_hold();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_busy", bsy8, 0);  chk("reset_done", dn8, 0);
      chk("reset_rd", rd8, 0);     chk("reset_wr", wr8, 0);
      chk("reset_serr", se8, 0);   chk("reset_stage", stg8, 0);
      chk("reset_rb", rb8, 0);     chk("reset64_busy", bsy64, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run8(-1, -1, -1);                         // plain schedule, done at 28
      hmask[2] = 1'b1; hmask[3] = 1'b1; hmask[4] = 1'b1;
      run8(-1, -1, -1);                         // 3-cycle hold in stage 0, done at 31
      clr_hold();
      run8(5, -1, -1);                          // missing mult_valid
      run8(-1, -1, -1);                         // new start clears sync_err
      run8(-1, 15, -1);                         // reset during stage-1 drain
      run8(-1, -1, -1);
      run8(-1, -1, 12);                         // start while issuing
      run8(-1, -1, 28);                         // start on the done cycle
      for (int r = 0; r < 6; r++) begin
         clr_hold();
         for (int k = 1; k < 60; k++) hmask[k] = ($urandom_range(0, 3) == 0);
         run8(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1, -1,
              int'($urandom_range(1, 25)));
      end
      clr_hold();

      n_rd = 0; n_wr = 0; mx = 0; dc = -1;
      for (int k = 0; k < 260; k++) begin
         @(negedge clk);
         st64 = (k == 0);
         #1;
         if (rd64) begin
            s = n_rd / 32; bb = n_rd % 32;
            span = 64 >> (s + 1);
            j = bb % span;
            a = 2 * (bb / span) * span + j;
            chk("rd64_a", ra64, a);
            chk("rd64_b", rb64, a + span);
            n_rd++;
         end
         if (wr64) n_wr++;
         if (me64 && int'(fi64) > mx) mx = int'(fi64);
         if (dn64) dc = k;
      end
      chk("n64_rd", n_rd, 192);
      chk("n64_wr", n_wr, 192);
      chk("n64_max_fi", mx, 31);
      chk("n64_done_cycle", dc, 223);
      chk("n64_sync_err", se64, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
